main_control_fsm: RTL and testbench



---
 rtl/main_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_main_control_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// main_control_fsm
//
// Multi-cycle main control unit for the MIPS datapath. It steps each
// instruction through fetch, decode, execute, memory and write-back. It
// drives every datapath enable and mux select, and it is the issuing side
// of the ALUOp interface that the ALU control decoder consumes. Memory
// accesses stall on the mem_ready handshake.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   opcode[3:0]    instruction-register opcode, stable from DECODE to next FETCH
//   mem_ready      memory completed the current access this cycle
//   pc_write, pc_write_cond, ir_write, reg_write   register enables
//   mem_read, mem_write, i_or_d                    memory control (i_or_d=1: ALU-out address)
//   mem_to_reg, reg_dst, alu_src_a                 mux selects
//   alu_src_b[1:0] 00 reg B, 01 const 1, 10 imm, 11 imm (branch offset)
//   pc_source[1:0] 00 ALU result, 01 ALU-out register, 10 jump target
//   alu_op[1:0]    00 R-type, 01 subtract, 10 slt, 11 add
//   illegal        sticky flag, set when an undefined opcode is decoded
//   state[3:0]     current state encoding, for debug

module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_SLTI  = 4'd2;
    localparam logic [3:0] OP_LW    = 4'd3;
    localparam logic [3:0] OP_SW    = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_J     = 4'd6;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_IMM_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   opcode_illegal;

    // Opcodes 0111 through 1111 are undefined.
    assign opcode_illegal = (opcode > OP_J);
    assign state          = cur_state;

    // State register. Reset drops straight to IDLE, so every output decodes
    // to zero as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Sticky illegal-opcode flag. It is set on leaving DECODE with an
    // undefined opcode and is cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (cur_state == S_DECODE && opcode_illegal) begin
            illegal <= 1'b1;
        end
    end

    // Next-state logic. The memory states hold until mem_ready is seen.
    // Unused encodings recover to FETCH.
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_IDLE:      nxt_state = S_FETCH;
            S_FETCH:     nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     nxt_state = S_MEM_ADDR;
                    OP_RTYPE:         nxt_state = S_EXECUTE;
                    OP_ADDI, OP_SLTI: nxt_state = S_IMM_EXEC;
                    OP_BEQ:           nxt_state = S_BRANCH;
                    OP_J:             nxt_state = S_JUMP;
                    default:          nxt_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    nxt_state = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    nxt_state = S_MEM_WRITE;
                end else begin
                    nxt_state = S_FETCH;
                end
            end
            S_MEM_READ:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    nxt_state = S_FETCH;
            S_MEM_WRITE: nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   nxt_state = S_R_WB;
            S_R_WB:      nxt_state = S_FETCH;
            S_IMM_EXEC:  nxt_state = S_IMM_WB;
            S_IMM_WB:    nxt_state = S_FETCH;
            S_BRANCH:    nxt_state = S_FETCH;
            S_JUMP:      nxt_state = S_FETCH;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Output decode. Every output defaults to 0. In FETCH, the IR and PC
    // write strobes follow mem_ready, so a stalled fetch does not write.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_SLTI) ? 2'b10 : 2'b11;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm
//
// Directed testbench for main_control_fsm. A single linear sequence of steps
// drives opcode and mem_ready, and each step compares the state, the packed
// control outputs and the illegal flag against hand-derived constants.
// The packed output vector has this bit order:
//   [15] pc_write [14] pc_write_cond [13] ir_write [12] reg_write
//   [11] mem_read [10] mem_write [9] i_or_d [8] mem_to_reg
//   [7] reg_dst [6] alu_src_a [5:4] alu_src_b [3:2] pc_source [1:0] alu_op

module tb_main_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    int checks;
    int failures;

    // Expected packed outputs for each state. Groups are
    // [pw pwc irw rw]_[mr mw iod m2r]_[rd asa]_[asb]_[ps]_[aop].
    localparam logic [15:0] O_ZERO      = 16'b0000_0000_00_00_00_00;
    localparam logic [15:0] O_FETCH     = 16'b1010_1000_00_01_00_11;
    localparam logic [15:0] O_FETCH_STL = 16'b0000_1000_00_01_00_11;
    localparam logic [15:0] O_DECODE    = 16'b0000_0000_00_11_00_11;
    localparam logic [15:0] O_MEM_ADDR  = 16'b0000_0000_01_10_00_11;
    localparam logic [15:0] O_MEM_READ  = 16'b0000_1010_00_00_00_00;
    localparam logic [15:0] O_MEM_WB    = 16'b0001_0001_00_00_00_00;
    localparam logic [15:0] O_MEM_WRITE = 16'b0000_0110_00_00_00_00;
    localparam logic [15:0] O_EXECUTE   = 16'b0000_0000_01_00_00_00;
    localparam logic [15:0] O_R_WB      = 16'b0001_0000_10_00_00_00;
    localparam logic [15:0] O_ADDI_EX   = 16'b0000_0000_01_10_00_11;
    localparam logic [15:0] O_SLTI_EX   = 16'b0000_0000_01_10_00_10;
    localparam logic [15:0] O_IMM_WB    = 16'b0001_0000_00_00_00_00;
    localparam logic [15:0] O_BRANCH    = 16'b0100_0000_01_00_01_01;
    localparam logic [15:0] O_JUMP      = 16'b1000_0000_00_00_10_00;

    main_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal       (illegal),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] op, input logic mr);
        opcode    = op;
        mem_ready = mr;
        #1;
    endtask

    // Compare the state, the packed outputs and the illegal flag.
    task automatic checkOutput(input string tag, input logic [3:0] exp_state,
                               input logic [15:0] exp_out, input logic exp_ill);
        logic [15:0] obs;
        obs = {pc_write, pc_write_cond, ir_write, reg_write,
               mem_read, mem_write, i_or_d, mem_to_reg,
               reg_dst, alu_src_a, alu_src_b, pc_source, alu_op};
        checks++;
        assert (state === exp_state) else begin
            failures++;
            $error("[TB] FAIL %s.state observed=%0d expected=%0d", tag, state, exp_state);
        end
        checks++;
        assert (obs === exp_out) else begin
            failures++;
            $error("[TB] FAIL %s.outputs observed=%b expected=%b", tag, obs, exp_out);
        end
        checks++;
        assert (illegal === exp_ill) else begin
            failures++;
            $error("[TB] FAIL %s.illegal observed=%b expected=%b", tag, illegal, exp_ill);
        end
    endtask

    // Advance one clock, drive the inputs for the new cycle, and check.
    task automatic step(input string tag, input logic [3:0] op, input logic mr,
                        input logic [3:0] exp_state, input logic [15:0] exp_out,
                        input logic exp_ill);
        @(posedge clk);
        #2;
        applyStimulus(op, mr);
        checkOutput(tag, exp_state, exp_out, exp_ill);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        opcode   = 4'd0;
        mem_ready = 1'b1;
        #2;
        applyStimulus(4'd0, 1'b1);
        checkOutput("reset", 4'd0, O_ZERO, 1'b0);
        step("reset_hold", 4'd0, 1'b1, 4'd0, O_ZERO, 1'b0);

        // R-type: 0,1,2,7,8,1
        rst_n = 1'b1;
        applyStimulus(4'd0, 1'b1);
        checkOutput("rt_idle", 4'd0, O_ZERO, 1'b0);
        step("rt_fetch",   4'd0, 1'b1, 4'd1, O_FETCH,   1'b0);
        step("rt_decode",  4'd0, 1'b1, 4'd2, O_DECODE,  1'b0);
        step("rt_execute", 4'd0, 1'b1, 4'd7, O_EXECUTE, 1'b0);
        step("rt_wb",      4'd0, 1'b1, 4'd8, O_R_WB,    1'b0);

        // lw with one fetch stall and two MEM_READ stalls
        step("lw_fetch_stall", 4'd3, 1'b0, 4'd1, O_FETCH_STL, 1'b0);
        step("lw_fetch",    4'd3, 1'b1, 4'd1, O_FETCH,    1'b0);
        step("lw_decode",   4'd3, 1'b1, 4'd2, O_DECODE,   1'b0);
        step("lw_addr",     4'd3, 1'b1, 4'd3, O_MEM_ADDR, 1'b0);
        step("lw_read0",    4'd3, 1'b0, 4'd4, O_MEM_READ, 1'b0);
        step("lw_read1",    4'd3, 1'b0, 4'd4, O_MEM_READ, 1'b0);
        step("lw_read2",    4'd3, 1'b1, 4'd4, O_MEM_READ, 1'b0);
        step("lw_wb",       4'd3, 1'b1, 4'd5, O_MEM_WB,   1'b0);

        // slti
        step("slti_fetch",  4'd2, 1'b1, 4'd1,  O_FETCH,   1'b0);
        step("slti_decode", 4'd2, 1'b1, 4'd2,  O_DECODE,  1'b0);
        step("slti_exec",   4'd2, 1'b1, 4'd9,  O_SLTI_EX, 1'b0);
        step("slti_wb",     4'd2, 1'b1, 4'd10, O_IMM_WB,  1'b0);

        // addi
        step("addi_fetch",  4'd1, 1'b1, 4'd1,  O_FETCH,   1'b0);
        step("addi_decode", 4'd1, 1'b1, 4'd2,  O_DECODE,  1'b0);
        step("addi_exec",   4'd1, 1'b1, 4'd9,  O_ADDI_EX, 1'b0);
        step("addi_wb",     4'd1, 1'b1, 4'd10, O_IMM_WB,  1'b0);

        // beq
        step("beq_fetch",   4'd5, 1'b1, 4'd1,  O_FETCH,   1'b0);
        step("beq_decode",  4'd5, 1'b1, 4'd2,  O_DECODE,  1'b0);
        step("beq_branch",  4'd5, 1'b1, 4'd11, O_BRANCH,  1'b0);

        // j
        step("j_fetch",     4'd6, 1'b1, 4'd1,  O_FETCH,   1'b0);
        step("j_decode",    4'd6, 1'b1, 4'd2,  O_DECODE,  1'b0);
        step("j_jump",      4'd6, 1'b1, 4'd12, O_JUMP,    1'b0);

        // sw without stall
        step("sw_fetch",    4'd4, 1'b1, 4'd1, O_FETCH,     1'b0);
        step("sw_decode",   4'd4, 1'b1, 4'd2, O_DECODE,    1'b0);
        step("sw_addr",     4'd4, 1'b1, 4'd3, O_MEM_ADDR,  1'b0);
        step("sw_write",    4'd4, 1'b1, 4'd6, O_MEM_WRITE, 1'b0);

        // illegal opcode 1010 sets the sticky flag on returning to FETCH
        step("ill_fetch",   4'd10, 1'b1, 4'd1, O_FETCH,  1'b0);
        step("ill_decode",  4'd10, 1'b1, 4'd2, O_DECODE, 1'b0);
        step("ill_refetch", 4'd0,  1'b1, 4'd1, O_FETCH,  1'b1);
        step("ill_rt_decode",  4'd0, 1'b1, 4'd2, O_DECODE,  1'b1);
        step("ill_rt_execute", 4'd0, 1'b1, 4'd7, O_EXECUTE, 1'b1);
        step("ill_rt_wb",      4'd0, 1'b1, 4'd8, O_R_WB,    1'b1);

        // sw stalled in MEM_WRITE, then reset mid-instruction
        step("swr_fetch",   4'd4, 1'b1, 4'd1, O_FETCH,     1'b1);
        step("swr_decode",  4'd4, 1'b1, 4'd2, O_DECODE,    1'b1);
        step("swr_addr",    4'd4, 1'b1, 4'd3, O_MEM_ADDR,  1'b1);
        step("swr_write0",  4'd4, 1'b0, 4'd6, O_MEM_WRITE, 1'b1);
        step("swr_write1",  4'd4, 1'b0, 4'd6, O_MEM_WRITE, 1'b1);
        rst_n = 1'b0;
        applyStimulus(4'd4, 1'b0);
        checkOutput("swr_reset", 4'd0, O_ZERO, 1'b0);
        step("swr_reset_hold", 4'd4, 1'b1, 4'd0, O_ZERO, 1'b0);
        rst_n = 1'b1;
        applyStimulus(4'd0, 1'b1);
        checkOutput("swr_idle", 4'd0, O_ZERO, 1'b0);
        step("swr_resume_fetch",  4'd0, 1'b1, 4'd1, O_FETCH,  1'b0);
        step("swr_resume_decode", 4'd0, 1'b1, 4'd2, O_DECODE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
